// File: rtl/accel_pkg.sv
// Shared constants and FSM encodings for the accelerator core and its packer.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package accel_pkg;

    localparam int BIT_WIDTH  = 8;
    localparam int NUM_KERNEL = 4;
    localparam int REG_WIDTH  = 32;
    localparam int LANES      = 4;
    localparam int OUT_WIDTH  = BIT_WIDTH * LANES;

    // Packer run-control states
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

endpackage

// File: rtl/psum_lane_fifo.sv
// Per-kernel psum packer: gathers bytes into words, tags the final word, buffers words.
// Latency: word is written into the FIFO at the end of the cycle its last byte is valid.
// Backpressure: none on the psum input; a write into a full, unread FIFO is dropped and flagged.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   i_clear         start-of-run clear of counter, lane, FIFO and overflow flag
//   i_run           psums are accepted only while high
//   i_en, i_cnt     latched kernel enable and psum count for this run
//   i_psum(_val)    incoming psum byte stream
//   i_rd            pop the FIFO head (ignored when empty)
//   o_word, o_last  FIFO head word and its last tag
//   o_empty         FIFO empty
//   o_finished      kernel has nothing more to accept this run
//   o_overflow      sticky: a word was dropped because the FIFO was full
module psum_lane_fifo #(
    parameter int BIT_WIDTH  = 8,
    parameter int OUT_WIDTH  = 32,
    parameter int REG_WIDTH  = 32,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_clear,
    input  logic                 i_run,
    input  logic                 i_en,
    input  logic [REG_WIDTH-1:0] i_cnt,
    input  logic [BIT_WIDTH-1:0] i_psum,
    input  logic                 i_psum_val,
    input  logic                 i_rd,
    output logic [OUT_WIDTH-1:0] o_word,
    output logic                 o_last,
    output logic                 o_empty,
    output logic                 o_finished,
    output logic                 o_overflow
);

    localparam int LANES = OUT_WIDTH / BIT_WIDTH;
    localparam int LB    = $clog2(LANES);
    localparam int AW    = $clog2(FIFO_DEPTH);

    logic [REG_WIDTH-1:0] cnt_q, cnt_d;
    logic [OUT_WIDTH-1:0] lane_q, lane_d;
    logic                 done_q, done_d;
    logic [AW:0]          wr_ptr_q, wr_ptr_d;
    logic [AW:0]          rd_ptr_q, rd_ptr_d;
    logic                 ovf_q, ovf_d;
    logic [OUT_WIDTH:0]   mem_q [FIFO_DEPTH];

    logic                 accept;
    logic [LB-1:0]        byte_idx;
    logic [REG_WIDTH-1:0] cnt_inc;
    logic                 hit_cnt;
    logic                 wr_req;
    logic                 wr_en;
    logic                 rd_en;
    logic                 full;
    logic [OUT_WIDTH-1:0] word_new;

    // Disabled kernels and empty runs are finished from the first RUN cycle.
    assign o_finished = !i_en || (i_cnt == '0) || done_q;
    assign accept     = i_run && i_psum_val && !o_finished;
    assign byte_idx   = cnt_q[LB-1:0];
    assign cnt_inc    = cnt_q + REG_WIDTH'(1);
    assign hit_cnt    = (cnt_inc == i_cnt);
    assign wr_req     = accept && ((byte_idx == LB'(LANES - 1)) || hit_cnt);

    // Extra pointer MSB distinguishes full from empty.
    assign o_empty = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign rd_en   = i_rd && !o_empty;
    // A simultaneous pop frees a slot, so a write into a full FIFO still lands.
    assign wr_en   = wr_req && (!full || rd_en);

    // Lane bytes above the current one are always zero, so a short final
    // word comes out zero-padded without extra masking.
    always_comb begin
        word_new = lane_q;
        word_new[byte_idx*BIT_WIDTH +: BIT_WIDTH] = i_psum;
    end

    always_comb begin
        cnt_d    = cnt_q;
        lane_d   = lane_q;
        done_d   = done_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        ovf_d    = ovf_q;
        if (accept) begin
            cnt_d  = cnt_inc;
            lane_d = wr_req ? '0 : word_new;
            if (hit_cnt) begin
                done_d = 1'b1;
            end
        end
        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + (AW+1)'(1);
        end
        if (rd_en) begin
            rd_ptr_d = rd_ptr_q + (AW+1)'(1);
        end
        if (wr_req && !wr_en) begin
            ovf_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            cnt_q    <= '0;
            lane_q   <= '0;
            done_q   <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            ovf_q    <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            lane_q   <= lane_d;
            done_q   <= done_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            ovf_q    <= ovf_d;
        end
    end

    // Storage needs no reset: pointers define which entries are valid.
    always_ff @(posedge clk) begin
        if (wr_en && !rst && !i_clear) begin
            mem_q[wr_ptr_q[AW-1:0]] <= {hit_cnt, word_new};
        end
    end

    assign o_word     = mem_q[rd_ptr_q[AW-1:0]][OUT_WIDTH-1:0];
    assign o_last     = mem_q[rd_ptr_q[AW-1:0]][OUT_WIDTH];
    assign o_overflow = ovf_q;

endmodule

// File: rtl/psum_output_packer.sv
// Packs four per-kernel psum byte streams into 32-bit words and round-robins them out.
// Latency: 2 cycles from the psum completing a word to o_data_val; sustains 1 word/cycle.
// Backpressure: i_data_rdy stalls the output register (held stable); psum inputs cannot stall.
//
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   i_psum_knN, i_psum_knN_val   per-kernel psum byte streams (N = 0..3)
//   i_conf_ctrl[0]               run level; i_conf_cnt psums per kernel; i_conf_knx[3:0] enable mask
//   o_data, o_data_val, o_data_kn, o_data_last, i_data_rdy   valid/ready word stream
//   o_done                       run complete; o_overflow sticky per-kernel drop flags
module psum_output_packer #(
    parameter int BIT_WIDTH  = accel_pkg::BIT_WIDTH,
    parameter int NUM_KERNEL = accel_pkg::NUM_KERNEL,
    parameter int OUT_WIDTH  = accel_pkg::OUT_WIDTH,
    parameter int FIFO_DEPTH = 8,
    parameter int REG_WIDTH  = accel_pkg::REG_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [BIT_WIDTH-1:0]  i_psum_kn0,
    input  logic [BIT_WIDTH-1:0]  i_psum_kn1,
    input  logic [BIT_WIDTH-1:0]  i_psum_kn2,
    input  logic [BIT_WIDTH-1:0]  i_psum_kn3,
    input  logic                  i_psum_kn0_val,
    input  logic                  i_psum_kn1_val,
    input  logic                  i_psum_kn2_val,
    input  logic                  i_psum_kn3_val,
    input  logic [REG_WIDTH-1:0]  i_conf_ctrl,
    input  logic [REG_WIDTH-1:0]  i_conf_cnt,
    input  logic [REG_WIDTH-1:0]  i_conf_knx,
    output logic [OUT_WIDTH-1:0]  o_data,
    output logic                  o_data_val,
    output logic [1:0]            o_data_kn,
    output logic                  o_data_last,
    input  logic                  i_data_rdy,
    output logic                  o_done,
    output logic [NUM_KERNEL-1:0] o_overflow
);

    import accel_pkg::*;

    localparam int KW = $clog2(NUM_KERNEL);

    logic [1:0]            state_q, state_d;
    logic [REG_WIDTH-1:0]  cnt_q;
    logic [NUM_KERNEL-1:0] mask_q;
    logic [KW-1:0]         rr_q;
    logic [OUT_WIDTH-1:0]  out_dat_q;
    logic                  out_val_q;
    logic [KW-1:0]         out_kn_q;
    logic                  out_last_q;

    logic [BIT_WIDTH-1:0]  psum_arr [NUM_KERNEL];
    logic [NUM_KERNEL-1:0] psum_val;
    logic [OUT_WIDTH-1:0]  lane_word [NUM_KERNEL];
    logic [NUM_KERNEL-1:0] lane_last;
    logic [NUM_KERNEL-1:0] lane_empty;
    logic [NUM_KERNEL-1:0] lane_fin;
    logic [NUM_KERNEL-1:0] rd_vec;

    logic                  clear;
    logic                  run;
    logic [KW-1:0]         grant;
    logic                  any_req;
    logic                  load;
    logic                  accept_out;
    logic                  out_empty_next;
    logic                  all_empty;

    logic unused_cfg;
    assign unused_cfg = ^{i_conf_ctrl[REG_WIDTH-1:1], i_conf_knx[REG_WIDTH-1:NUM_KERNEL]};

    assign psum_arr[0] = i_psum_kn0;
    assign psum_arr[1] = i_psum_kn1;
    assign psum_arr[2] = i_psum_kn2;
    assign psum_arr[3] = i_psum_kn3;
    assign psum_val    = {i_psum_kn3_val, i_psum_kn2_val, i_psum_kn1_val, i_psum_kn0_val};

    assign clear = (state_q == ST_IDLE) && i_conf_ctrl[0];
    assign run   = (state_q == ST_RUN);

    for (genvar k = 0; k < NUM_KERNEL; k++) begin : g_lane
        psum_lane_fifo #(
            .BIT_WIDTH  (BIT_WIDTH),
            .OUT_WIDTH  (OUT_WIDTH),
            .REG_WIDTH  (REG_WIDTH),
            .FIFO_DEPTH (FIFO_DEPTH)
        ) u_lane (
            .clk        (clk),
            .rst        (rst),
            .i_clear    (clear),
            .i_run      (run),
            .i_en       (mask_q[k]),
            .i_cnt      (cnt_q),
            .i_psum     (psum_arr[k]),
            .i_psum_val (psum_val[k]),
            .i_rd       (rd_vec[k]),
            .o_word     (lane_word[k]),
            .o_last     (lane_last[k]),
            .o_empty    (lane_empty[k]),
            .o_finished (lane_fin[k]),
            .o_overflow (o_overflow[k])
        );
    end

    // Round-robin: first non-empty FIFO at or after the pointer.
    always_comb begin
        logic [KW-1:0] idx;
        grant   = '0;
        any_req = 1'b0;
        idx     = '0;
        for (int i = 0; i < NUM_KERNEL; i++) begin
            idx = rr_q + KW'(i);
            if (!any_req && !lane_empty[idx]) begin
                grant   = idx;
                any_req = 1'b1;
            end
        end
    end

    assign accept_out     = out_val_q && i_data_rdy;
    assign load           = any_req && (!out_val_q || i_data_rdy);
    assign rd_vec         = load ? (NUM_KERNEL'(1) << grant) : '0;
    assign all_empty      = &lane_empty;
    // Output register will be empty after this edge; lets o_done follow the final accept by one cycle.
    assign out_empty_next = !out_val_q || (accept_out && !load);

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (i_conf_ctrl[0]) state_d = ST_RUN;
            ST_RUN:   if (&lane_fin) state_d = (all_empty && out_empty_next) ? ST_DONE : ST_DRAIN;
            ST_DRAIN: if (all_empty && out_empty_next) state_d = ST_DONE;
            ST_DONE:  if (!i_conf_ctrl[0]) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            mask_q     <= '0;
            rr_q       <= '0;
            out_dat_q  <= '0;
            out_val_q  <= 1'b0;
            out_kn_q   <= '0;
            out_last_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (clear) begin
                cnt_q  <= i_conf_cnt;
                mask_q <= i_conf_knx[NUM_KERNEL-1:0];
            end
            if (load) begin
                out_dat_q  <= lane_word[grant];
                out_kn_q   <= grant;
                out_last_q <= lane_last[grant];
                out_val_q  <= 1'b1;
                rr_q       <= grant + KW'(1);
            end else if (accept_out) begin
                out_val_q  <= 1'b0;
            end
        end
    end

    assign o_data      = out_dat_q;
    assign o_data_val  = out_val_q;
    assign o_data_kn   = out_kn_q;
    assign o_data_last = out_last_q;
    assign o_done      = (state_q == ST_DONE);

endmodule

// File: tb/tb_psum_output_packer.sv
module tb_psum_output_packer;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  psum [4];
    logic [3:0]  pval;
    logic [31:0] i_conf_ctrl, i_conf_cnt, i_conf_knx;
    logic [31:0] o_data;
    logic        o_data_val;
    logic [1:0]  o_data_kn;
    logic        o_data_last;
    logic        i_data_rdy;
    logic        o_done;
    logic [3:0]  o_overflow;

    always #5 clk = ~clk;

    psum_output_packer dut (
        .clk            (clk),
        .rst            (rst),
        .i_psum_kn0     (psum[0]),
        .i_psum_kn1     (psum[1]),
        .i_psum_kn2     (psum[2]),
        .i_psum_kn3     (psum[3]),
        .i_psum_kn0_val (pval[0]),
        .i_psum_kn1_val (pval[1]),
        .i_psum_kn2_val (pval[2]),
        .i_psum_kn3_val (pval[3]),
        .i_conf_ctrl    (i_conf_ctrl),
        .i_conf_cnt     (i_conf_cnt),
        .i_conf_knx     (i_conf_knx),
        .o_data         (o_data),
        .o_data_val     (o_data_val),
        .o_data_kn      (o_data_kn),
        .o_data_last    (o_data_last),
        .i_data_rdy     (i_data_rdy),
        .o_done         (o_done),
        .o_overflow     (o_overflow)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int rdy_mode = 0;
    bit chk_en = 1'b0;

    // Expected words per kernel: {last, data}
    logic [32:0] exp_q [4][$];
    int          order_q [$];
    logic [31:0] k0_q [$];
    int          n_acc = 0;
    int          last_acc_cyc = 0;

    bit          prev_stall = 1'b0;
    logic [31:0] prev_dat;
    logic [1:0]  prev_kn;
    logic        prev_last;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Ready pattern generator
    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            0:       i_data_rdy = 1'b1;
            1:       i_data_rdy = ((cyc % 4) == 0) || ((cyc % 4) == 3);
            default: i_data_rdy = 1'b0;
        endcase
    end

    // Compare process: every accepted word must be the next expected word of its kernel,
    // and a stalled word must not change.
    always @(negedge clk) begin
        if (chk_en && !rst) begin
            if (prev_stall) begin
                check("hold_val",  {63'd0, o_data_val}, 64'd1);
                check("hold_dat",  {32'd0, o_data}, {32'd0, prev_dat});
                check("hold_kn",   {62'd0, o_data_kn}, {62'd0, prev_kn});
                check("hold_last", {63'd0, o_data_last}, {63'd0, prev_last});
            end
            if (o_data_val && i_data_rdy) begin
                if (exp_q[o_data_kn].size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_word: kn=%0d data=0x%08h, none expected", o_data_kn, o_data);
                end else begin
                    logic [32:0] e;
                    e = exp_q[o_data_kn].pop_front();
                    check("word_dat",  {32'd0, o_data}, {32'd0, e[31:0]});
                    check("word_last", {63'd0, o_data_last}, {63'd0, e[32]});
                end
                order_q.push_back(int'(o_data_kn));
                if (o_data_kn == 2'd0) k0_q.push_back(o_data);
                n_acc++;
                last_acc_cyc = cyc;
            end
            prev_stall = o_data_val && !i_data_rdy;
            prev_dat   = o_data;
            prev_kn    = o_data_kn;
            prev_last  = o_data_last;
        end else begin
            prev_stall = 1'b0;
        end
    end

    // Model: kernel k's j-th driven psum is k*16+j; only the first cnt of an
    // enabled kernel count; bytes pack little-end first, last word marks count reached.
    task automatic build_model(input int cnt, input logic [3:0] mask, input int n);
        for (int k = 0; k < 4; k++) begin
            exp_q[k].delete();
            if (mask[k] && cnt > 0) begin
                int m;
                m = (n < cnt) ? n : cnt;
                for (int w = 0; w * 4 < m; w++) begin
                    logic [31:0] word;
                    logic        lst;
                    word = 32'd0;
                    for (int b = 0; b < 4; b++) begin
                        if (w * 4 + b < m) word = word | (32'(k * 16 + w * 4 + b) << (8 * b));
                    end
                    lst = (w * 4 + 4 >= m) && (m == cnt);
                    exp_q[k].push_back({lst, word});
                end
            end
        end
        order_q.delete();
        k0_q.delete();
        n_acc = 0;
    endtask

    task automatic drive_psums(input int n);
        for (int j = 0; j < n; j++) begin
            @(posedge clk); #1;
            for (int k = 0; k < 4; k++) psum[k] = 8'(k * 16 + j);
            pval = 4'hF;
        end
        @(posedge clk); #1;
        pval = 4'h0;
    endtask

    task automatic start_run(input int cnt, input logic [3:0] mask, input int n, input int mode);
        build_model(cnt, mask, n);
        rdy_mode = mode;
        chk_en   = 1'b1;
        @(posedge clk); #1;
        i_conf_cnt  = 32'(cnt);
        i_conf_knx  = {28'd0, mask};
        i_conf_ctrl = 32'd1;
        drive_psums(n);
    endtask

    task automatic finish_run(input string name);
        int i;
        i = 0;
        while (!o_done && i < 300) begin
            @(negedge clk);
            i++;
        end
        if (!o_done) begin
            total++;
            bad++;
            $display("FAIL %s_done_timeout: o_done=0 after %0d cycles, expected 1", name, i);
        end else if (n_acc > 0) begin
            check({name, "_done_lat"}, 64'(cyc), 64'(last_acc_cyc + 1));
        end
        for (int k = 0; k < 4; k++) check({name, "_leftover"}, 64'(exp_q[k].size()), 64'd0);
        @(posedge clk); #1;
        i_conf_ctrl = 32'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check({name, "_idle_done"}, {63'd0, o_done}, 64'd0);
    endtask

    initial begin
        int c0;
        int ord_exp [8];
        ord_exp = '{0, 1, 2, 3, 0, 1, 2, 3};
        rst = 1'b1;
        pval = 4'h0;
        for (int k = 0; k < 4; k++) psum[k] = 8'h00;
        i_conf_ctrl = 32'd0;
        i_conf_cnt  = 32'd0;
        i_conf_knx  = 32'd0;
        i_data_rdy  = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_val",  {63'd0, o_data_val}, 64'd0);
        check("rst_data", {32'd0, o_data}, 64'd0);
        check("rst_done", {63'd0, o_done}, 64'd0);
        check("rst_ovf",  {60'd0, o_overflow}, 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // cnt=8, all kernels, always ready
        start_run(8, 4'hF, 8, 0);
        finish_run("c8");
        check("c8_nwords", 64'(n_acc), 64'd8);
        for (int i = 0; i < 8; i++) begin
            if (i < order_q.size()) check("c8_order", 64'(order_q[i]), 64'(ord_exp[i]));
        end
        check("c8_k0_cnt", 64'(k0_q.size()), 64'd2);
        if (k0_q.size() == 2) begin
            check("c8_k0_w0", {32'd0, k0_q[0]}, 64'h03020100);
            check("c8_k0_w1", {32'd0, k0_q[1]}, 64'h07060504);
        end

        // cnt=6, kernel 0 only: partial final word zero-padded
        start_run(6, 4'h1, 6, 0);
        finish_run("c6");
        check("c6_nwords", 64'(n_acc), 64'd2);
        if (k0_q.size() == 2) begin
            check("c6_k0_w0", {32'd0, k0_q[0]}, 64'h03020100);
            check("c6_k0_w1", {32'd0, k0_q[1]}, 64'h00000504);
        end

        // cnt=4 with ready toggling 1-0-0-1
        start_run(4, 4'hF, 4, 1);
        finish_run("c4rdy");
        check("c4rdy_nwords", 64'(n_acc), 64'd4);

        // Overflow: ready low, 40 psums into kernel 2 (10 words)
        start_run(40, 4'b0100, 40, 2);
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("ovf_flag", {60'd0, o_overflow}, 64'h4);
        check("ovf_hold_val", {63'd0, o_data_val}, 64'd1);
        check("ovf_hold_w0", {32'd0, o_data}, 64'h23222120);
        check("ovf_not_done", {63'd0, o_done}, 64'd0);
        void'(exp_q[2].pop_back());   // 10th word is the dropped one
        rdy_mode = 0;
        finish_run("ovf");
        check("ovf_nwords", 64'(n_acc), 64'd9);

        // cnt=0: immediate completion, no words
        build_model(0, 4'hF, 0);
        @(posedge clk); #1;
        i_conf_cnt  = 32'd0;
        i_conf_knx  = 32'hF;
        i_conf_ctrl = 32'd1;
        c0 = cyc;
        begin
            int i;
            i = 0;
            while (!o_done && i < 10) begin
                @(negedge clk);
                i++;
            end
        end
        check("c0_done", {63'd0, o_done}, 64'd1);
        check("c0_lat_ok", {63'd0, (cyc - c0) <= 2}, 64'd1);
        check("c0_ovf_cleared", {60'd0, o_overflow}, 64'd0);
        finish_run("c0");
        check("c0_nwords", 64'(n_acc), 64'd0);

        // Reset mid-run, then a clean cnt=4 run
        start_run(8, 4'hF, 5, 0);
        chk_en = 1'b0;
        rst = 1'b1;
        i_conf_ctrl = 32'd0;
        @(posedge clk);
        @(negedge clk);
        check("mrst_val",  {63'd0, o_data_val}, 64'd0);
        check("mrst_data", {32'd0, o_data}, 64'd0);
        check("mrst_kn",   {62'd0, o_data_kn}, 64'd0);
        check("mrst_last", {63'd0, o_data_last}, 64'd0);
        check("mrst_done", {63'd0, o_done}, 64'd0);
        check("mrst_ovf",  {60'd0, o_overflow}, 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        start_run(4, 4'hF, 4, 0);
        finish_run("post_rst");
        check("post_rst_nwords", 64'(n_acc), 64'd4);
        if (k0_q.size() == 1) check("post_rst_k0", {32'd0, k0_q[0]}, 64'h03020100);
        else check("post_rst_k0_cnt", 64'(k0_q.size()), 64'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, expected to finish", $time);
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1, "watchdog");
    end

endmodule
